// File: rtl/alu_flag_unit.sv
// Status register for an 8-bit CPU: six stored flags, a one-deep pending
// ALU-update slot aligned to ALU8's one-cycle latency, and decimal adjust.
module alu_flag_unit #(
    parameter logic [7:0] P_INIT = 8'h04
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rdy,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic       alu_hc,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       bcd_adc,
    input  logic       bcd_sbc,
    input  logic       bit_test,
    input  logic [7:0] mem,
    input  logic [2:0] flag_op,
    input  logic       plp,
    input  logic [7:0] p_in,
    input  logic       php_b,
    output logic [7:0] adj_out,
    output logic [7:0] p_out,
    output logic       c_flag,
    output logic       d_flag,
    output logic       i_flag
);

    logic r_n, r_v, r_d, r_i, r_z, r_c;
    logic w_n, w_v, w_d, w_i, w_z, w_c;

    // Pending slot: what the operation issued last cycle wants to update
    logic r_p_nz, r_p_c, r_p_v, r_p_adc, r_p_sbc, r_p_bt, r_p_m7, r_p_m6;

    logic [3:0] w_lo, w_hi;

    // ALU8's N flag is superseded by adj_out[7]; these operand bits have no role here
    logic w_unused;
    assign w_unused = ^{alu_n, p_in[5:4], mem[5:0]};

    always_comb begin
        w_lo = alu_out[3:0];
        w_hi = alu_out[7:4];
        if (r_p_adc) begin
            if (alu_hc) w_lo = w_lo + 4'd6;
            if (alu_co) w_hi = w_hi + 4'd6;
        end else if (r_p_sbc) begin
            if (!alu_hc) w_lo = w_lo - 4'd6;
            if (!alu_co) w_hi = w_hi - 4'd6;
        end
        adj_out = {w_hi, w_lo};
    end

    // Later assignments win: flag_op < pending ALU update < plp
    always_comb begin
        w_n = r_n;
        w_v = r_v;
        w_d = r_d;
        w_i = r_i;
        w_z = r_z;
        w_c = r_c;

        case (flag_op)
            3'd1:    w_c = 1'b0;
            3'd2:    w_c = 1'b1;
            3'd3:    w_i = 1'b0;
            3'd4:    w_i = 1'b1;
            3'd5:    w_d = 1'b0;
            3'd6:    w_d = 1'b1;
            3'd7:    w_v = 1'b0;
            default: ;
        endcase

        if (r_p_bt) begin
            w_n = r_p_m7;
            w_v = r_p_m6;
            w_z = alu_z;
        end else begin
            if (r_p_nz) begin
                w_n = adj_out[7];
                w_z = (adj_out == 8'h00);
            end
            if (r_p_v) w_v = alu_v;
        end
        if (r_p_c) w_c = alu_co;

        if (plp) begin
            w_n = p_in[7];
            w_v = p_in[6];
            w_d = p_in[3];
            w_i = p_in[2];
            w_z = p_in[1];
            w_c = p_in[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n     <= P_INIT[7];
            r_v     <= P_INIT[6];
            r_d     <= P_INIT[3];
            r_i     <= P_INIT[2];
            r_z     <= P_INIT[1];
            r_c     <= P_INIT[0];
            r_p_nz  <= 1'b0;
            r_p_c   <= 1'b0;
            r_p_v   <= 1'b0;
            r_p_adc <= 1'b0;
            r_p_sbc <= 1'b0;
            r_p_bt  <= 1'b0;
            r_p_m7  <= 1'b0;
            r_p_m6  <= 1'b0;
        end else if (rdy) begin
            r_n     <= w_n;
            r_v     <= w_v;
            r_d     <= w_d;
            r_i     <= w_i;
            r_z     <= w_z;
            r_c     <= w_c;
            // Capturing the new issue both retires the old entry and replaces it
            r_p_nz  <= upd_nz;
            r_p_c   <= upd_c;
            r_p_v   <= upd_v;
            r_p_adc <= bcd_adc;
            r_p_sbc <= bcd_sbc;
            r_p_bt  <= bit_test;
            r_p_m7  <= mem[7];
            r_p_m6  <= mem[6];
        end
    end

    assign p_out  = {r_n, r_v, 1'b1, php_b, r_d, r_i, r_z, r_c};
    assign c_flag = r_c;
    assign d_flag = r_d;
    assign i_flag = r_i;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed-vector bench for alu_flag_unit; expected values are hand-computed.
module tb_alu_flag_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rdy;
    logic [7:0] alu_out;
    logic       alu_co, alu_v, alu_z, alu_n, alu_hc;
    logic       upd_nz, upd_c, upd_v, bcd_adc, bcd_sbc, bit_test;
    logic [7:0] mem;
    logic [2:0] flag_op;
    logic       plp;
    logic [7:0] p_in;
    logic       php_b;
    logic [7:0] adj_out, p_out;
    logic       c_flag, d_flag, i_flag;

    int n_checks = 0;
    int n_fail   = 0;

    alu_flag_unit #(.P_INIT(8'h04)) dut (
        .clk(clk), .reset_n(reset_n), .rdy(rdy), .alu_out(alu_out),
        .alu_co(alu_co), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n), .alu_hc(alu_hc),
        .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v),
        .bcd_adc(bcd_adc), .bcd_sbc(bcd_sbc), .bit_test(bit_test), .mem(mem),
        .flag_op(flag_op), .plp(plp), .p_in(p_in), .php_b(php_b),
        .adj_out(adj_out), .p_out(p_out),
        .c_flag(c_flag), .d_flag(d_flag), .i_flag(i_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end else begin
            $display("ok   %s: %02h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        upd_nz = 0; upd_c = 0; upd_v = 0; bcd_adc = 0; bcd_sbc = 0;
        bit_test = 0; mem = 8'h00; flag_op = 3'd0; plp = 0; p_in = 8'h00;
    endtask

    task automatic do_flag_op(input logic [2:0] op);
        flag_op = op;
        tick();
        flag_op = 3'd0;
    endtask

    task automatic do_plp(input logic [7:0] v);
        plp = 1; p_in = v;
        tick();
        plp = 0; p_in = 8'h00;
    endtask

    logic [2:0] ops  [6] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5};
    logic [7:0] exps [6] = '{8'h25, 8'h24, 8'h20, 8'h24, 8'h2C, 8'h24};

    initial begin
        reset_n = 0; rdy = 1; alu_out = 8'h00;
        alu_co = 0; alu_v = 0; alu_z = 0; alu_n = 0; alu_hc = 0; php_b = 0;
        clear_ctl();
        #12;
        check("reset p_out", p_out, 8'h24);
        check("reset c/d/i", {5'b0, c_flag, d_flag, i_flag}, 8'h01);
        @(negedge clk);
        reset_n = 1;
        tick();
        check("post-release p_out", p_out, 8'h24);

        for (int k = 0; k < 6; k++) begin
            do_flag_op(ops[k]);
            check($sformatf("flag_op %0d", ops[k]), p_out, exps[k]);
        end

        // Decimal add: low nibble adjust only
        do_flag_op(3'd2);
        bcd_adc = 1; upd_nz = 1; upd_c = 1;
        tick();
        clear_ctl();
        alu_out = 8'h1A; alu_hc = 1; alu_co = 0;
        #1 check("adc adj_out", adj_out, 8'h10);
        tick();
        check("adc flags", p_out, 8'h24);

        // Decimal subtract: low nibble adjust only, C from ALU
        bcd_sbc = 1; upd_c = 1;
        tick();
        clear_ctl();
        alu_out = 8'h0F; alu_hc = 0; alu_co = 1;
        #1 check("sbc adj_out", adj_out, 8'h09);
        tick();
        check("sbc flags", p_out, 8'h25);

        bcd_adc = 1;
        tick();
        clear_ctl();
        alu_out = 8'h9A; alu_hc = 1; alu_co = 1;
        #1 check("adc both nibbles", adj_out, 8'hF0);
        tick();
        bcd_sbc = 1;
        tick();
        clear_ctl();
        alu_out = 8'h00; alu_hc = 0; alu_co = 0;
        #1 check("sbc both nibbles", adj_out, 8'hAA);
        tick();

        upd_nz = 1;
        tick();
        clear_ctl();
        alu_out = 8'h00; alu_hc = 1; alu_co = 1;
        #1 check("binary adj_out", adj_out, 8'h00);
        tick();
        check("binary Z set", p_out, 8'h27);

        // Stall in T+1 holds the pending update
        do_flag_op(3'd1);
        check("clc", p_out, 8'h26);
        upd_c = 1;
        tick();
        clear_ctl();
        rdy = 0; alu_co = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall C hold %0d", k), {7'b0, c_flag}, 8'h00);
        end
        rdy = 1;
        tick();
        check("stall C applied", {7'b0, c_flag}, 8'h01);

        // Collision priority
        upd_c = 1;
        tick();
        clear_ctl();
        alu_co = 0; flag_op = 3'd2;
        tick();
        flag_op = 3'd0;
        check("alu beats SEC", {7'b0, c_flag}, 8'h00);
        upd_c = 1;
        tick();
        clear_ctl();
        alu_co = 0; flag_op = 3'd2; plp = 1; p_in = 8'hFF;
        tick();
        clear_ctl();
        check("plp beats all C", {7'b0, c_flag}, 8'h01);
        check("plp p_out", p_out, 8'hEF);
        php_b = 1;
        #1 check("php_b in p_out", p_out, 8'hFF);
        php_b = 0;
        do_flag_op(3'd7);
        check("clv", p_out, 8'hAF);

        // BIT overrides upd_nz / upd_v
        do_plp(8'h00);
        check("plp zero", p_out, 8'h20);
        bit_test = 1; mem = 8'hC0; upd_nz = 1; upd_v = 1;
        tick();
        clear_ctl();
        alu_out = 8'h01; alu_z = 1; alu_v = 0; alu_co = 0;
        tick();
        check("bit_test flags", p_out, 8'hE2);

        // Back-to-back issue replaces the pending entry
        upd_c = 1;
        tick();
        clear_ctl();
        alu_co = 1; upd_nz = 1; alu_out = 8'h80;
        tick();
        clear_ctl();
        check("b2b first", p_out, 8'hE3);
        alu_out = 8'h00; alu_co = 0;
        tick();
        check("b2b second", p_out, 8'h63);
        alu_out = 8'h80; alu_co = 1;
        tick();
        check("pending cleared", p_out, 8'h63);

        // Reset mid-operation discards the pending update
        do_plp(8'hFF);
        check("preset all", p_out, 8'hEF);
        upd_nz = 1;
        tick();
        clear_ctl();
        alu_out = 8'h80;
        #2 reset_n = 0;
        #1 check("async reset", p_out, 8'h24);
        #2 reset_n = 1;
        tick();
        check("no update after reset", p_out, 8'h24);
        tick();
        check("still reset value", p_out, 8'h24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
